// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, PC step and queue entry type for the fetch unit
package fetch_pkg;
  localparam int FETCH_ADDRESS_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH    = 32;
  localparam int PC_STEP             = 4;

  typedef struct packed {
    logic [FETCH_ADDRESS_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0]    instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO of fetch entries with flush and occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  entry_t        mem_q [DEPTH];

  always_comb begin
    do_pop  = pop && (count_q != '0) && !flush;
    // a full queue can still take a write when the head leaves in the same cycle
    do_push = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC sequencing, memory issue, redirect flush and output queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH    = FETCH_DATA_WIDTH,
  parameter int                       DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;

  // same layout as fetch_entry_t, sized to this instance's widths
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic                     inflight_q, inflight_d;
  logic [CW-1:0]            fifo_count;
  logic [CW:0]              occupancy;
  logic                     issue, push, pop;
  entry_t                   wr_entry, rd_entry;

  always_comb begin
    occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    // reserving a slot for the response in flight is what keeps pushes off a full queue
    issue      = rst && en && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (issue) begin
      pc_d     = pc_q + ADDRESS_WIDTH'(PC_STEP);
      req_pc_d = pc_q;
    end
    // a redirect kills the response landing this cycle and ignores any pop
    push           = inflight_q && !redirect_valid;
    pop            = out_valid && out_ready && !redirect_valid;
    wr_entry.pc    = req_pc_q;
    wr_entry.instr = imem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (fifo_count)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign out_valid = (fifo_count != '0);
  assign out_instr = rd_entry.instr;
  assign out_pc    = rd_entry.pc;
  assign count     = fifo_count;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (fifo_count == CW'(DEPTH))));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit against a program-order model
module tb_fetch_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clk = 1'b0;
  logic          rst, en, redirect_valid, out_ready;
  logic [AW-1:0] redirect_target, imem_addr, out_pc;
  logic          imem_req, out_valid;
  logic [DW-1:0] imem_rdata, out_instr;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .RESET_PC      (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .count           (count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: data for the address requested in the previous cycle, junk otherwise
  logic          req_s = 1'b0;
  logic [AW-1:0] addr_s = '0;
  always @(posedge clk) imem_rdata <= req_s ? instr_of(addr_s) : $urandom;

  // reference model: program-order stream of expected pcs, restarted on redirect/reset
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_tail = '0;
  logic [AW-1:0] fetch_pc = '0;
  logic          prev_req = 1'b0;

  task automatic restart(input logic [AW-1:0] pc);
    exp_q.delete();
    exp_tail = pc;
  endtask

  always @(negedge clk) begin
    req_s  = imem_req;
    addr_s = imem_addr;
    if (!rst) begin
      chk("reset_req", 64'(imem_req), 64'(0));
      chk("reset_valid", 64'(out_valid), 64'(0));
      chk("reset_count", 64'(count), 64'(0));
      restart(RESET_PC);
      fetch_pc = RESET_PC;
      prev_req = 1'b0;
    end else begin
      chk("req_rule", 64'(imem_req),
          64'(en && !redirect_valid && ((int'(count) + int'(prev_req)) < DEPTH)));
      if (imem_req) chk("req_addr", 64'(imem_addr), 64'(fetch_pc));
      chk("valid_rule", 64'(out_valid), 64'(count != 0));
      chk("count_bound", 64'(int'(count) <= DEPTH), 64'(1));
      if (out_valid && out_ready && !redirect_valid) begin
        accepted++;
        chk("out_pc", 64'(out_pc), 64'(exp_q[0]));
        chk("out_instr", 64'(out_instr), 64'(instr_of(exp_q[0])));
        void'(exp_q.pop_front());
      end
      if (redirect_valid) begin
        fetch_pc = redirect_target & ~32'h3;
        restart(fetch_pc);
      end else if (imem_req) begin
        fetch_pc = fetch_pc + 32'd4;
      end
      prev_req = imem_req;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int n, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (int'(count) != n && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(count), 64'(n));
  endtask

  task automatic startup_checks(input string tag);
    @(negedge clk);
    chk({tag, "_first_req"}, 64'(imem_req), 64'(1));
    chk({tag, "_first_addr"}, 64'(imem_addr), 64'(RESET_PC));
    chk({tag, "_valid_c0"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_valid_c1"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_valid_c2"}, 64'(out_valid), 64'(1));
    chk({tag, "_pc0"}, 64'(out_pc), 64'(RESET_PC));
    @(negedge clk);
    chk({tag, "_pc1"}, 64'(out_pc), 64'(RESET_PC + 32'd4));
    @(negedge clk);
    chk({tag, "_pc2"}, 64'(out_pc), 64'(RESET_PC + 32'd8));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    startup_checks("boot");

    for (int i = 0; i < 20; i++) begin
      cyc();
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // backpressure for 10 cycles
    cyc(); out_ready = 1'b0;
    repeat (9) cyc();
    @(negedge clk);
    chk("bp_count", 64'(count), 64'(4));
    chk("bp_req", 64'(imem_req), 64'(0));
    cyc(); out_ready = 1'b1;
    repeat (3) cyc();

    // unaligned redirect target: low bits dropped
    redirect_valid = 1'b1; redirect_target = 32'h103;
    cyc(); redirect_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rdA_count", 64'(count), 64'(0));
    chk("rdA_req", 64'(imem_req), 64'(1));
    chk("rdA_addr", 64'(imem_addr), 64'(32'h100));

    // redirect with three queued and one in flight, pop requested that cycle
    wait_count(2, "rdB_fill");
    cyc(); redirect_valid = 1'b1; redirect_target = 32'h104; out_ready = 1'b1;
    @(negedge clk);
    chk("rdB_count_pre", 64'(count), 64'(3));
    chk("rdB_req_pre", 64'(imem_req), 64'(0));
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdB_count", 64'(count), 64'(0));
    chk("rdB_req", 64'(imem_req), 64'(1));
    chk("rdB_addr", 64'(imem_addr), 64'(32'h104));

    // fetch stall mid-stream
    repeat (5) cyc();
    cyc(); en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      chk("stall_req", 64'(imem_req), 64'(0));
    end
    cyc(); en = 1'b1;

    // full queue then drain
    cyc(); out_ready = 1'b0;
    wait_count(4, "full_fill");
    chk("full_req", 64'(imem_req), 64'(0));
    cyc(); out_ready = 1'b1;
    @(negedge clk);
    chk("full_hold", 64'(count), 64'(4));
    @(negedge clk);
    chk("full_pop", 64'(count), 64'(3));

    for (int i = 0; i < 40; i++) begin
      cyc();
      en              = ($urandom_range(0, 7) != 0);
      out_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
    end

    // reset while two entries are queued
    cyc(); en = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200; out_ready = 1'b0;
    cyc(); redirect_valid = 1'b0;
    wait_count(2, "rst_fill");
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_req", 64'(imem_req), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; out_ready = 1'b1;
    startup_checks("rerun");

    for (int i = 0; i < 20; i++) begin
      cyc();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    chk("enough_accepted", 64'(accepted >= 40), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
